maq_regressiva: RTL and testbench
=================================

// Module: maq_regressiva
// PURPOSE
//  MM:SS countdown timer for the digital clock (timer mode): the decrementing counterpart of the minutes/seconds counters.
//  Loads a BCD preset and counts down one second per maqr_tick to 00:00 with borrow across digits.
//  Raises an alarm at zero. Drives the same BCD digit format (3-bit MSD, 4-bit LSD) as the display path.
// PARAMETERS
//  ALARM_TICKS  10  ticks the alarm stays active in DONE before auto-return to IDLE; 0 = hold until acknowledged
//  MIN_MSD_MAX  5   max minutes MSD accepted on load (1..7); seconds MSD max is fixed at 5
// PORTS
//  maqr_clock          in   1  system clock, rising edge
//  maqr_reset          in   1  asynchronous, active-high reset
//  maqr_tick           in   1  1 Hz enable, one maqr_clock cycle wide
//  maqr_start_stop     in   1  debounced single-cycle command pulse
//  maqr_load           in   1  load preset (single cycle)
//  maqr_load_min_msd   in   3  preset minutes MSD
//  maqr_load_min_lsd   in   4  preset minutes LSD
//  maqr_load_sec_msd   in   3  preset seconds MSD
//  maqr_load_sec_lsd   in   4  preset seconds LSD
//  maqr_min_msd        out  3  current minutes MSD (registered)
//  maqr_min_lsd        out  4  current minutes LSD (registered)
//  maqr_sec_msd        out  3  current seconds MSD (registered)
//  maqr_sec_lsd        out  4  current seconds LSD (registered)
//  maqr_running        out  1  1 while state==RUN (registered)
//  maqr_zero           out  1  combinational: all four digits == 0
//  maqr_alarm          out  1  alarm (registered)
// BEHAVIOUR
//  Reset (async, immediate): all digits 0, state IDLE, running 0, alarm 0, alarm tick count 0.
//  States (2-bit): IDLE, RUN, PAUSE, DONE. Priority within a cycle: reset > load > start_stop > tick.
//  Load: accepted in IDLE/PAUSE/DONE. Digits are captured at the next edge and clamped:
//   - LSD >9 -> 9.
//   - sec MSD >5 -> 5.
//   - min MSD >MIN_MSD_MAX -> MIN_MSD_MAX.
//   Load forces IDLE and clears alarm. Load in RUN is ignored entirely. start_stop in a load cycle is ignored.
//  IDLE: start_stop -> RUN if maqr_zero==0; else stays IDLE. Ticks ignored.
//  RUN: each tick decrements by 1 s at that edge.
//   - sec_lsd 0->9 borrows from sec_msd; sec_msd 0->5 borrows from min_lsd; min_lsd 0->9 borrows from min_msd.
//   - Tick at 00:01 -> 00:00, state DONE, alarm=1 at the same edge. Count never wraps below 00:00.
//   - start_stop -> PAUSE. start_stop+tick in the same cycle: decrement applied AND -> PAUSE.
//  PAUSE: ticks ignored, digits held. start_stop -> RUN; the tick in that same cycle is not applied.
//  DONE: digits stay 00:00. Each tick increments the alarm tick count.
//   - When the count reaches ALARM_TICKS (nonzero): -> IDLE, alarm 0, count cleared.
//   - start_stop acknowledges: -> IDLE, alarm 0, count cleared.
//  running is 1 exactly while the state is RUN. A start_stop in any state not listed above has no effect.
// CONFIGURATION
//  MAQR_ALARM_BLINK_EN defined: in DONE, alarm starts at 1 and toggles on every tick (1 Hz blink period 2 s).
//   It is forced 0 on exit from DONE.
//  MAQR_ALARM_BLINK_EN undefined: alarm held steady at 1 for the whole of DONE.
//  Timeout and acknowledge behaviour are identical in both builds.
// TESTING
//  1. reset; load 01:00; start_stop; 1 tick -> 00:59, running=1, alarm=0.
//  2. load 00:02; start; 2 ticks -> 00:00, DONE, alarm=1 after 2nd tick edge.
//     Then 10 ticks -> alarm=0, IDLE (ALARM_TICKS=10). Blink build: alarm toggles each tick.
//  3. IDLE at 00:00; start_stop -> stays IDLE, running=0. Separately, 10:00 running, 1 tick -> 09:59 (full borrow chain).
//  4. RUN at 10:00; start_stop+tick same cycle -> 09:59, PAUSE. 3 ticks -> 09:59.
//     load 05:30 during a prior RUN -> ignored. load 05:30 in PAUSE -> IDLE, 05:30.
//  5. load min 7/F, sec 7/F (MIN_MSD_MAX=5) -> 59:59. Start; 1 tick -> 59:58.
//  6. Assert reset between clock edges mid-RUN at 03:17 -> all digits 0, running=0, alarm=0 before the next edge.

Source files
------------

// File: rtl/maq_regressiva_if.sv
// Bus bundle for the maq_regressiva MM:SS countdown timer: command/preset inputs and BCD digit outputs.
interface maq_regressiva_if;
  logic       maqr_tick;
  logic       maqr_start_stop;
  logic       maqr_load;
  logic [2:0] maqr_load_min_msd;
  logic [3:0] maqr_load_min_lsd;
  logic [2:0] maqr_load_sec_msd;
  logic [3:0] maqr_load_sec_lsd;
  logic [2:0] maqr_min_msd;
  logic [3:0] maqr_min_lsd;
  logic [2:0] maqr_sec_msd;
  logic [3:0] maqr_sec_lsd;
  logic       maqr_running;
  logic       maqr_zero;
  logic       maqr_alarm;

  modport master (
    output maqr_tick, maqr_start_stop, maqr_load,
    output maqr_load_min_msd, maqr_load_min_lsd, maqr_load_sec_msd, maqr_load_sec_lsd,
    input  maqr_min_msd, maqr_min_lsd, maqr_sec_msd, maqr_sec_lsd,
    input  maqr_running, maqr_zero, maqr_alarm
  );

  modport slave (
    input  maqr_tick, maqr_start_stop, maqr_load,
    input  maqr_load_min_msd, maqr_load_min_lsd, maqr_load_sec_msd, maqr_load_sec_lsd,
    output maqr_min_msd, maqr_min_lsd, maqr_sec_msd, maqr_sec_lsd,
    output maqr_running, maqr_zero, maqr_alarm
  );
endinterface

// File: rtl/maq_regressiva.sv
// MM:SS BCD countdown timer with alarm at 00:00 and optional auto-return after ALARM_TICKS ticks.
// Build option MAQR_ALARM_BLINK_EN: alarm toggles on every tick while in DONE instead of holding at 1.
module maq_regressiva #(
  parameter int ALARM_TICKS = 10,
  parameter int MIN_MSD_MAX = 5
) (
  input logic             maqr_clock,
  input logic             maqr_reset,
  maq_regressiva_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int         CNT_W        = $clog2(ALARM_TICKS + 2);
  localparam logic [2:0] MIN_MSD_LIM  = 3'(MIN_MSD_MAX);
  localparam logic [2:0] SEC_MSD_LIM  = 3'd5;
  localparam bit         HAS_TIMEOUT  = (ALARM_TICKS > 32'sd0);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(ALARM_TICKS);

  // Time word packing: {min_msd[2:0], min_lsd[3:0], sec_msd[2:0], sec_lsd[3:0]}
  function automatic logic [3:0] clamp_lsd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [2:0] clamp_msd(input logic [2:0] d, input logic [2:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [13:0] dec_time(input logic [13:0] t);
    logic [2:0] mm;
    logic [3:0] ml;
    logic [2:0] sm;
    logic [3:0] sl;
    {mm, ml, sm, sl} = t;
    if (t == 14'd0) begin
      return t;
    end else if (sl != 4'd0) begin
      sl = sl - 4'd1;
    end else begin
      sl = 4'd9;
      if (sm != 3'd0) begin
        sm = sm - 3'd1;
      end else begin
        sm = SEC_MSD_LIM;
        if (ml != 4'd0) begin
          ml = ml - 4'd1;
        end else begin
          ml = 4'd9;
          mm = mm - 3'd1;
        end
      end
    end
    return {mm, ml, sm, sl};
  endfunction

  state_t            state_r;
  state_t            state_s;
  logic [13:0]       time_r;
  logic [13:0]       time_s;
  logic [13:0]       dec_s;
  logic [13:0]       preset_s;
  logic              alarm_r;
  logic              alarm_s;
  logic              running_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic              load_ok_s;
  logic              timeout_s;
  logic              zero_s;

  assign zero_s    = (time_r == 14'd0);
  assign dec_s     = dec_time(time_r);
  // Load is only honoured outside RUN; in RUN it is as if it never happened
  assign load_ok_s = bus.maqr_load && (state_r != ST_RUN);
  assign preset_s  = {clamp_msd(bus.maqr_load_min_msd, MIN_MSD_LIM),
                      clamp_lsd(bus.maqr_load_min_lsd),
                      clamp_msd(bus.maqr_load_sec_msd, SEC_MSD_LIM),
                      clamp_lsd(bus.maqr_load_sec_lsd)};
  assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
  assign timeout_s = HAS_TIMEOUT && (cnt_inc_s == CNT_LIM);

  // State register
  always_ff @(posedge maqr_clock or posedge maqr_reset) begin
    if (maqr_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: load > start_stop > tick
  always_comb begin
    state_s = state_r;
    if (load_ok_s) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.maqr_start_stop && !zero_s) state_s = ST_RUN;
          else                                state_s = ST_IDLE;
        end
        ST_RUN: begin
          if (bus.maqr_tick && (dec_s == 14'd0)) state_s = ST_DONE;
          else if (bus.maqr_start_stop)          state_s = ST_PAUSE;
          else                                   state_s = ST_RUN;
        end
        ST_PAUSE: begin
          if (bus.maqr_start_stop) state_s = ST_RUN;
          else                     state_s = ST_PAUSE;
        end
        ST_DONE: begin
          if (bus.maqr_start_stop)             state_s = ST_IDLE;
          else if (bus.maqr_tick && timeout_s) state_s = ST_IDLE;
          else                                 state_s = ST_DONE;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Output/datapath next values: digits, alarm level and alarm tick count
  always_comb begin
    time_s  = time_r;
    alarm_s = alarm_r;
    cnt_s   = cnt_r;
    if (load_ok_s) begin
      time_s  = preset_s;
      alarm_s = 1'b0;
      cnt_s   = '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.maqr_tick) begin
            time_s = dec_s;
            if (dec_s == 14'd0) begin
              alarm_s = 1'b1;
              cnt_s   = '0;
            end else begin
              alarm_s = 1'b0;
            end
          end else begin
            time_s = time_r;
          end
        end
        ST_DONE: begin
          if (bus.maqr_start_stop || (bus.maqr_tick && timeout_s)) begin
            alarm_s = 1'b0;
            cnt_s   = '0;
          end else if (bus.maqr_tick) begin
            cnt_s = cnt_inc_s;
`ifdef MAQR_ALARM_BLINK_EN
            alarm_s = ~alarm_r;
`else
            alarm_s = 1'b1;
`endif
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_IDLE, ST_PAUSE: begin
          alarm_s = 1'b0;
          cnt_s   = '0;
        end
        default: begin
          time_s  = 14'd0;
          alarm_s = 1'b0;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // Output registers
  always_ff @(posedge maqr_clock or posedge maqr_reset) begin
    if (maqr_reset) begin
      time_r    <= 14'd0;
      alarm_r   <= 1'b0;
      cnt_r     <= '0;
      running_r <= 1'b0;
    end else begin
      time_r    <= time_s;
      alarm_r   <= alarm_s;
      cnt_r     <= cnt_s;
      running_r <= (state_s == ST_RUN);
    end
  end

  assign bus.maqr_min_msd = time_r[13:11];
  assign bus.maqr_min_lsd = time_r[10:7];
  assign bus.maqr_sec_msd = time_r[6:4];
  assign bus.maqr_sec_lsd = time_r[3:0];
  assign bus.maqr_running = running_r;
  assign bus.maqr_alarm   = alarm_r;
  assign bus.maqr_zero    = zero_s;

endmodule

// File: tb/tb_maq_regressiva.sv
// Scoreboard bench for maq_regressiva: expected digit/status snapshots queued per driven cycle.
module tb_maq_regressiva;

  logic clk = 1'b0;
  logic rst = 1'b0;
  maq_regressiva_if bus();

  maq_regressiva #(.ALARM_TICKS(10), .MIN_MSD_MAX(5)) dut (
    .maqr_clock (clk),
    .maqr_reset (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tk;
    logic        ss;
    logic        ld;
    logic [13:0] pre;
    logic [13:0] t;
    logic        run;
    logic        alm;
  } vec_t;

  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  wire [13:0] obs_t = {bus.maqr_min_msd, bus.maqr_min_lsd, bus.maqr_sec_msd, bus.maqr_sec_lsd};

`ifdef MAQR_ALARM_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  function automatic logic [13:0] tm(input int a, input int b, input int c, input int d);
    return {3'(a), 4'(b), 3'(c), 4'(d)};
  endfunction

  function automatic vec_t mk(input logic tk, input logic ss, input logic ld, input logic [13:0] pre,
                              input logic [13:0] t, input logic run, input logic alm);
    vec_t v;
    v.tk = tk; v.ss = ss; v.ld = ld; v.pre = pre; v.t = t; v.run = run; v.alm = alm;
    return v;
  endfunction

  initial begin
    bus.maqr_tick = 1'b0; bus.maqr_start_stop = 1'b0; bus.maqr_load = 1'b0;
    bus.maqr_load_min_msd = 3'd0; bus.maqr_load_min_lsd = 4'd0;
    bus.maqr_load_sec_msd = 3'd0; bus.maqr_load_sec_lsd = 4'd0;
  end

  // Drive one cycle of inputs from a negedge, leaving time at the following negedge
  task automatic step(input logic tk, input logic ss, input logic ld, input logic [13:0] pre);
    bus.maqr_tick = tk; bus.maqr_start_stop = ss; bus.maqr_load = ld;
    {bus.maqr_load_min_msd, bus.maqr_load_min_lsd, bus.maqr_load_sec_msd, bus.maqr_load_sec_lsd} = pre;
    @(negedge clk);
    bus.maqr_tick = 1'b0; bus.maqr_start_stop = 1'b0; bus.maqr_load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    vec_t e;
    #2 rst = 1'b1;
    #1;
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 14'd0, 14'd0, 1'b0, 1'b0));
    e = sb.pop_front();
    total++;
    if ({obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero} !== {e.t, e.run, e.alm, 1'b1}) begin
      bad++;
      $display("FAIL reset_async: got t=%h run=%b alm=%b zero=%b want t=%h run=0 alm=0 zero=1",
               obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero, e.t);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 14'd0, 14'd0, 1'b0, 1'b0));
    step(1'b1, 1'b0, 1'b0, 14'd0);
    e = sb.pop_front();
    total++;
    if ({obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero} !== {e.t, e.run, e.alm, 1'b1}) begin
      bad++;
      $display("FAIL reset_idle: got t=%h run=%b alm=%b zero=%b want t=%h run=0 alm=0 zero=1",
               obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero, e.t);
    end
  endtask

  task automatic test_basic();
    vec_t v[$];
    vec_t e;
    do_reset();
    v.push_back(mk(1'b0, 1'b0, 1'b1, tm(0,1,0,0), tm(0,1,0,0), 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       tm(0,1,0,0), 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,       tm(0,1,0,0), 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       tm(0,0,5,9), 1'b1, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 14'd0,       tm(0,0,5,9), 1'b1, 1'b0));
    foreach (v[i]) begin
      sb.push_back(v[i]);
      step(v[i].tk, v[i].ss, v[i].ld, v[i].pre);
      e = sb.pop_front();
      total++;
      if ({obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero} !== {e.t, e.run, e.alm, e.t == 14'd0}) begin
        bad++;
        $display("FAIL basic[%0d]: got t=%h run=%b alm=%b zero=%b want t=%h run=%b alm=%b",
                 i, obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero, e.t, e.run, e.alm);
      end
    end
  endtask

  task automatic test_alarm_timeout();
    vec_t v[$];
    vec_t e;
    do_reset();
    v.push_back(mk(1'b0, 1'b0, 1'b1, tm(0,0,0,2), tm(0,0,0,2), 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,       tm(0,0,0,2), 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       tm(0,0,0,1), 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       14'd0,       1'b0, 1'b1));
    for (int k = 1; k <= 10; k++) begin
      logic a;
      if (k == 10)   a = 1'b0;
      else if (BLINK) a = (k % 2 == 0);
      else           a = 1'b1;
      v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0, 14'd0, 1'b0, a));
    end
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0, 14'd0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0, 14'd0, 1'b0, 1'b0));
    foreach (v[i]) begin
      sb.push_back(v[i]);
      step(v[i].tk, v[i].ss, v[i].ld, v[i].pre);
      e = sb.pop_front();
      total++;
      if ({obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero} !== {e.t, e.run, e.alm, e.t == 14'd0}) begin
        bad++;
        $display("FAIL alarm[%0d]: got t=%h run=%b alm=%b zero=%b want t=%h run=%b alm=%b",
                 i, obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero, e.t, e.run, e.alm);
      end
    end
  endtask

  task automatic test_pause_load();
    vec_t v[$];
    vec_t e;
    do_reset();
    v.push_back(mk(1'b0, 1'b0, 1'b1, tm(1,0,0,0), tm(1,0,0,0), 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,       tm(1,0,0,0), 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b1, 1'b0, 14'd0,       tm(0,9,5,9), 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       tm(0,9,5,9), 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       tm(0,9,5,9), 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       tm(0,9,5,9), 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b1, 1'b0, 14'd0,       tm(0,9,5,9), 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       tm(0,9,5,8), 1'b1, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b1, tm(0,5,3,0), tm(0,9,5,8), 1'b1, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,       tm(0,9,5,8), 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b1, tm(0,5,3,0), tm(0,5,3,0), 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,       tm(0,5,3,0), 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       tm(0,5,2,9), 1'b1, 1'b0));
    foreach (v[i]) begin
      sb.push_back(v[i]);
      step(v[i].tk, v[i].ss, v[i].ld, v[i].pre);
      e = sb.pop_front();
      total++;
      if ({obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero} !== {e.t, e.run, e.alm, e.t == 14'd0}) begin
        bad++;
        $display("FAIL pause_load[%0d]: got t=%h run=%b alm=%b zero=%b want t=%h run=%b alm=%b",
                 i, obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero, e.t, e.run, e.alm);
      end
    end
  endtask

  task automatic test_clamp_borrow();
    vec_t v[$];
    vec_t e;
    logic [13:0] raw_a;
    logic [13:0] raw_b;
    raw_a = {3'd3, 4'hC, 3'd6, 4'hA};
    raw_b = {3'd7, 4'hF, 3'd7, 4'hF};
    do_reset();
    v.push_back(mk(1'b0, 1'b0, 1'b1, raw_a,       tm(3,9,5,9), 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b1, raw_b,       tm(5,9,5,9), 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,       tm(5,9,5,9), 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       tm(5,9,5,8), 1'b1, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,       tm(5,9,5,8), 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b1, tm(1,0,0,0), tm(1,0,0,0), 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,       tm(1,0,0,0), 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       tm(0,9,5,9), 1'b1, 1'b0));
    foreach (v[i]) begin
      sb.push_back(v[i]);
      step(v[i].tk, v[i].ss, v[i].ld, v[i].pre);
      e = sb.pop_front();
      total++;
      if ({obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero} !== {e.t, e.run, e.alm, e.t == 14'd0}) begin
        bad++;
        $display("FAIL clamp_borrow[%0d]: got t=%h run=%b alm=%b zero=%b want t=%h run=%b alm=%b",
                 i, obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero, e.t, e.run, e.alm);
      end
    end
  endtask

  task automatic test_ack();
    vec_t v[$];
    vec_t e;
    do_reset();
    v.push_back(mk(1'b0, 1'b0, 1'b1, tm(0,0,0,1), tm(0,0,0,1), 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b1, tm(0,0,0,1), tm(0,0,0,1), 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,       tm(0,0,0,1), 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       14'd0,       1'b0, 1'b1));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       14'd0,       1'b0, !BLINK));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,       14'd0,       1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,       14'd0,       1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b1, tm(0,0,0,1), tm(0,0,0,1), 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,       tm(0,0,0,1), 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 14'd0,       14'd0,       1'b0, 1'b1));
    v.push_back(mk(1'b0, 1'b0, 1'b1, tm(0,2,0,0), tm(0,2,0,0), 1'b0, 1'b0));
    foreach (v[i]) begin
      sb.push_back(v[i]);
      step(v[i].tk, v[i].ss, v[i].ld, v[i].pre);
      e = sb.pop_front();
      total++;
      if ({obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero} !== {e.t, e.run, e.alm, e.t == 14'd0}) begin
        bad++;
        $display("FAIL ack[%0d]: got t=%h run=%b alm=%b zero=%b want t=%h run=%b alm=%b",
                 i, obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero, e.t, e.run, e.alm);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t v[$];
    vec_t e;
    do_reset();
    v.push_back(mk(1'b0, 1'b0, 1'b1, tm(0,3,1,7), tm(0,3,1,7), 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 14'd0,       tm(0,3,1,7), 1'b1, 1'b0));
    foreach (v[i]) begin
      sb.push_back(v[i]);
      step(v[i].tk, v[i].ss, v[i].ld, v[i].pre);
      e = sb.pop_front();
      total++;
      if ({obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero} !== {e.t, e.run, e.alm, e.t == 14'd0}) begin
        bad++;
        $display("FAIL async_pre[%0d]: got t=%h run=%b alm=%b zero=%b want t=%h run=%b alm=%b",
                 i, obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero, e.t, e.run, e.alm);
      end
    end
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 14'd0, 14'd0, 1'b0, 1'b0));
    #2 rst = 1'b1;
    #1;
    e = sb.pop_front();
    total++;
    if ({obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero} !== {e.t, e.run, e.alm, 1'b1}) begin
      bad++;
      $display("FAIL async_mid_run: got t=%h run=%b alm=%b zero=%b want t=%h run=0 alm=0 zero=1",
               obs_t, bus.maqr_running, bus.maqr_alarm, bus.maqr_zero, e.t);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_alarm_timeout();
    test_pause_load();
    test_clamp_borrow();
    test_ack();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
